// File: rtl/ps2_pkg.sv
// Shared types and derived timing constants for the PS/2 host transmitter.
// The cycle-count helpers turn the clock rate and time parameters into counter loads.
package ps2_pkg;

    typedef enum logic [2:0] {
        IDLE,
        INHIBIT,
        START,
        BITS,
        ACK,
        RECOVER
    } state_t;

    // Data bits 0..7, odd parity, stop.
    localparam int FRAME_BITS = 10;

    localparam int DEF_CLK_HZ     = 48_000_000;
    localparam int DEF_INHIBIT_US = 100;
    localparam int DEF_TIMEOUT_MS = 15;

    function automatic int inhibit_cycles(input int clk_hz, input int inhibit_us);
        return (clk_hz / 1_000_000) * inhibit_us;
    endfunction

    function automatic int timeout_cycles(input int clk_hz, input int timeout_ms);
        return (clk_hz / 1000) * timeout_ms;
    endfunction

    // 4800 and 720000 cycles at the default parameters.
    localparam int INHIBIT_CYC = inhibit_cycles(DEF_CLK_HZ, DEF_INHIBIT_US);
    localparam int TIMEOUT_CYC = timeout_cycles(DEF_CLK_HZ, DEF_TIMEOUT_MS);

endpackage

// File: rtl/ps2_line_filter.sv
// Two-flop synchronizer plus a FILT-sample persistence filter for one PS/2 pad.
// o_fall pulses in the same cycle the filtered level first reads 0 after being 1.
module ps2_line_filter #(
    parameter int FILT = 8
) (
    input  logic clk_sys,
    input  logic reset_n,
    input  logic i_pad,
    output logic o_level,
    output logic o_fall
);

    localparam int CNT_W = (FILT > 1) ? $clog2(FILT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILT - 1);

    logic             r_sync1;
    logic             r_sync2;
    logic             r_level;
    logic             r_fall;
    logic [CNT_W-1:0] r_cnt;

    // The counter tracks how many consecutive samples have disagreed with r_level.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
            r_level <= 1'b1;
            r_fall  <= 1'b0;
            r_cnt   <= '0;
        end else begin
            // NOTE: non-blocking assignments keep every flop sampling pre-edge values,
            // so the synchronizer really is two stages deep regardless of statement order.
            r_sync1 <= i_pad;
            r_sync2 <= r_sync1;
            r_fall  <= 1'b0;
            if (r_sync2 == r_level) begin
                r_cnt <= '0;
            end else if (r_cnt == CNT_LAST) begin
                r_level <= r_sync2;
                r_fall  <= r_level;
                r_cnt   <= '0;
            end else begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

    assign o_level = r_level;
    assign o_fall  = r_fall;

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device byte transmitter: inhibit, start bit, device-clocked frame,
// ack sampling and a watchdog between device clock edges. Pad drives are open-drain enables.
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int CLK_HZ     = 48_000_000,
    parameter int INHIBIT_US = 100,
    parameter int TIMEOUT_MS = 15,
    parameter int FILT       = 8
) (
    input  logic       clk_sys,
    input  logic       reset_n,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       tx_done,
    output logic       tx_err,
    input  logic       ps2_clk_in,
    input  logic       ps2_dat_in,
    output logic       ps2_clk_oe,
    output logic       ps2_dat_oe
);

    localparam int INH_CYC = inhibit_cycles(CLK_HZ, INHIBIT_US);
    localparam int WD_CYC  = timeout_cycles(CLK_HZ, TIMEOUT_MS);
    localparam int INH_W   = $clog2(INH_CYC + 1);
    localparam int WD_W    = $clog2(WD_CYC + 1);

    localparam logic [INH_W-1:0] INH_LOAD = INH_W'(INH_CYC - 1);
    localparam logic [WD_W-1:0]  WD_LOAD  = WD_W'(WD_CYC - 1);
    localparam logic [3:0]       LAST_BIT = 4'(FRAME_BITS - 2);

    state_t                r_state;
    logic [INH_W-1:0]      r_cnt;
    logic [WD_W-1:0]       r_wdog;
    logic [FRAME_BITS-1:0] r_shift;
    logic [3:0]            r_bit_cnt;
    logic                  r_clk_oe;
    logic                  r_dat_oe;
    logic                  r_done;
    logic                  r_err;

    state_t                w_nxt_state;
    logic [INH_W-1:0]      w_nxt_cnt;
    logic [WD_W-1:0]       w_nxt_wdog;
    logic [FRAME_BITS-1:0] w_nxt_shift;
    logic [3:0]            w_nxt_bit_cnt;
    logic                  w_nxt_clk_oe;
    logic                  w_nxt_dat_oe;
    logic                  w_nxt_done;
    logic                  w_nxt_err;

    logic w_clk_level;
    logic w_clk_fall;
    logic w_dat_level;
    logic w_dat_fall;
    logic w_wd_active;
    logic w_wd_expire;

    ps2_line_filter #(.FILT(FILT)) u_clk_filter (
        .clk_sys (clk_sys),
        .reset_n (reset_n),
        .i_pad   (ps2_clk_in),
        .o_level (w_clk_level),
        .o_fall  (w_clk_fall)
    );

    ps2_line_filter #(.FILT(FILT)) u_dat_filter (
        .clk_sys (clk_sys),
        .reset_n (reset_n),
        .i_pad   (ps2_dat_in),
        .o_level (w_dat_level),
        .o_fall  (w_dat_fall)
    );

    // A device edge always wins over expiry in the same cycle.
    assign w_wd_active = (r_state == START) || (r_state == BITS) || (r_state == ACK);
    assign w_wd_expire = w_wd_active && !w_clk_fall && (r_wdog == '0);

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_wdog    <= '0;
            r_shift   <= '0;
            r_bit_cnt <= '0;
            r_clk_oe  <= 1'b0;
            r_dat_oe  <= 1'b0;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_state   <= w_nxt_state;
            r_cnt     <= w_nxt_cnt;
            r_wdog    <= w_nxt_wdog;
            r_shift   <= w_nxt_shift;
            r_bit_cnt <= w_nxt_bit_cnt;
            r_clk_oe  <= w_nxt_clk_oe;
            r_dat_oe  <= w_nxt_dat_oe;
            r_done    <= w_nxt_done;
            r_err     <= w_nxt_err;
        end
    end

    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves one
        // unassigned, which would otherwise infer a latch.
        w_nxt_state   = r_state;
        w_nxt_cnt     = r_cnt;
        w_nxt_wdog    = r_wdog;
        w_nxt_shift   = r_shift;
        w_nxt_bit_cnt = r_bit_cnt;
        w_nxt_done    = 1'b0;
        w_nxt_err     = 1'b0;

        if (w_wd_active) begin
            if (w_clk_fall) begin
                w_nxt_wdog = WD_LOAD;
            end else if (r_wdog != '0) begin
                w_nxt_wdog = r_wdog - WD_W'(1);
            end
        end

        unique case (r_state)
            IDLE: begin
                if (tx_valid) begin
                    w_nxt_shift = {1'b1, ~^tx_data, tx_data};
                    w_nxt_cnt   = INH_LOAD;
                    w_nxt_state = INHIBIT;
                end
            end
            INHIBIT: begin
                if (r_cnt == '0) begin
                    w_nxt_wdog  = WD_LOAD;
                    w_nxt_state = START;
                end else begin
                    w_nxt_cnt = r_cnt - INH_W'(1);
                end
            end
            START: begin
                // First device edge: bit 0 is already at r_shift[0].
                if (w_clk_fall) begin
                    w_nxt_bit_cnt = '0;
                    w_nxt_state   = BITS;
                end else if (w_wd_expire) begin
                    w_nxt_err   = 1'b1;
                    w_nxt_state = RECOVER;
                end
            end
            BITS: begin
                if (w_clk_fall) begin
                    w_nxt_shift = {1'b1, r_shift[FRAME_BITS-1:1]};
                    if (r_bit_cnt == LAST_BIT) begin
                        w_nxt_state = ACK;
                    end else begin
                        w_nxt_bit_cnt = r_bit_cnt + 4'd1;
                    end
                end else if (w_wd_expire) begin
                    w_nxt_err   = 1'b1;
                    w_nxt_state = RECOVER;
                end
            end
            ACK: begin
                if (w_clk_fall) begin
                    w_nxt_done  = !w_dat_level;
                    w_nxt_err   = w_dat_level;
                    w_nxt_state = RECOVER;
                end else if (w_wd_expire) begin
                    w_nxt_err   = 1'b1;
                    w_nxt_state = RECOVER;
                end
            end
            RECOVER: begin
                if (w_clk_level && w_dat_level) begin
                    w_nxt_state = IDLE;
                end
            end
            default: begin
                w_nxt_state = IDLE;
            end
        endcase

        // Pad enables are registered from the next state so the pads never glitch.
        w_nxt_clk_oe = (w_nxt_state == INHIBIT);
        w_nxt_dat_oe = ((w_nxt_state == INHIBIT) && (w_nxt_cnt == '0))
                    || (w_nxt_state == START)
                    || ((w_nxt_state == BITS) && !w_nxt_shift[0]);
    end

    assign tx_ready   = (r_state == IDLE);
    assign tx_done    = r_done;
    assign tx_err     = r_err;
    assign ps2_clk_oe = r_clk_oe;
    assign ps2_dat_oe = r_dat_oe;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Self-checking bench for ps2_host_tx with a behavioural PS/2 device on open-drain lines.
// Runs with shortened timing (100-cycle inhibit, 2000-cycle watchdog) to keep runs short.
module tb_ps2_host_tx;

    localparam int CLK_HZ     = 1_000_000;
    localparam int INHIBIT_US = 100;
    localparam int TIMEOUT_MS = 2;
    localparam int FILT       = 8;
    localparam int INH_CYC    = 100;
    localparam int WD_CYC     = 2000;
    localparam int H          = 25;

    logic       clk_sys = 1'b0;
    logic       reset_n = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic       tx_ready;
    logic       tx_done;
    logic       tx_err;
    logic       ps2_clk_in;
    logic       ps2_dat_in;
    logic       ps2_clk_oe;
    logic       ps2_dat_oe;

    logic dev_clk_low = 1'b0;
    logic dev_dat_low = 1'b0;
    logic glitch_low  = 1'b0;

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;
    int done_cnt    = 0;
    int err_cnt     = 0;

    assign ps2_clk_in = ~(ps2_clk_oe | dev_clk_low | glitch_low);
    assign ps2_dat_in = ~(ps2_dat_oe | dev_dat_low);

    ps2_host_tx #(
        .CLK_HZ     (CLK_HZ),
        .INHIBIT_US (INHIBIT_US),
        .TIMEOUT_MS (TIMEOUT_MS),
        .FILT       (FILT)
    ) dut (
        .clk_sys    (clk_sys),
        .reset_n    (reset_n),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .tx_done    (tx_done),
        .tx_err     (tx_err),
        .ps2_clk_in (ps2_clk_in),
        .ps2_dat_in (ps2_dat_in),
        .ps2_clk_oe (ps2_clk_oe),
        .ps2_dat_oe (ps2_dat_oe)
    );

    initial forever #5 clk_sys = ~clk_sys;

    initial forever begin
        @(posedge clk_sys);
        cyc++;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Frame as the device sees it: data LSB first, odd parity, stop.
    function automatic logic [9:0] model_frame(input logic [7:0] d);
        int ones;
        logic par;
        ones = 0;
        for (int i = 0; i < 8; i++) if (d[i]) ones++;
        par = (ones % 2 == 0) ? 1'b1 : 1'b0;
        return {1'b1, par, d};
    endfunction

    // Per-cycle rule checks and pulse counting.
    initial forever begin
        @(negedge clk_sys);
        check("done_err_exclusive", {31'd0, tx_done & tx_err}, 32'd0);
        if (tx_ready) begin
            check("idle_clk_released", {31'd0, ps2_clk_oe}, 32'd0);
            check("idle_dat_released", {31'd0, ps2_dat_oe}, 32'd0);
        end
        if (tx_done || tx_err) check("pulse_not_ready", {31'd0, tx_ready}, 32'd0);
        if (tx_done) done_cnt++;
        if (tx_err) err_cnt++;
    end

    initial begin
        #600_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end

    task automatic wait_ready(input string name);
        int n;
        n = 0;
        while (!tx_ready && n < 400) begin
            @(negedge clk_sys);
            n++;
        end
        check(name, {31'd0, tx_ready}, 32'd1);
    endtask

    task automatic request(input logic [7:0] d);
        wait_ready("ready_before_req");
        tx_data  = d;
        tx_valid = 1'b1;
        @(negedge clk_sys);
        tx_valid = 1'b0;
    endtask

    // Returns at the first START cycle; low = inhibit length, dhi = data-low cycles in it.
    task automatic wait_start(output int low, output int dhi);
        int n;
        n = 0;
        low = 0;
        dhi = 0;
        while (!ps2_clk_oe && n < 10) begin
            @(negedge clk_sys);
            n++;
        end
        check("inhibit_seen", {31'd0, ps2_clk_oe}, 32'd1);
        while (ps2_clk_oe && low < 4 * INH_CYC) begin
            low++;
            if (ps2_dat_oe) dhi++;
            @(negedge clk_sys);
        end
        check("start_bit_low", {31'd0, ps2_dat_oe}, 32'd1);
    endtask

    task automatic dev_pulse(input bit glitch, output logic s);
        dev_clk_low = 1'b1;
        repeat (H) @(negedge clk_sys);
        s = ps2_dat_in;
        dev_clk_low = 1'b0;
        if (glitch) begin
            repeat (14) @(negedge clk_sys);
            glitch_low = 1'b1;
            repeat (3) @(negedge clk_sys);
            glitch_low = 1'b0;
            repeat (H - 17) @(negedge clk_sys);
        end else begin
            repeat (H) @(negedge clk_sys);
        end
    endtask

    task automatic dev_frame(input bit glitch, input bit poke, output logic [9:0] f);
        logic s;
        repeat (30) @(negedge clk_sys);
        if (poke) begin
            tx_data  = 8'h55;
            tx_valid = 1'b1;
        end
        for (int k = 0; k < 10; k++) begin
            dev_pulse(glitch, s);
            f[k] = s;
            if (k == 2) tx_valid = 1'b0;
        end
    endtask

    task automatic dev_ack(input bit ack);
        dev_dat_low = ack;
        repeat (H) @(negedge clk_sys);
        dev_clk_low = 1'b1;
        repeat (H) @(negedge clk_sys);
        dev_clk_low = 1'b0;
        repeat (H) @(negedge clk_sys);
        dev_dat_low = 1'b0;
    endtask

    // Full transaction; compares the sampled frame with the model and with a literal.
    task automatic send(input logic [7:0] d, input bit ack, input bit glitch, input bit poke,
                        input logic [9:0] lit, input string name);
        int low, dhi, d0, e0;
        logic [9:0] f;
        request(d);
        wait_start(low, dhi);
        check({name, "_inhibit_len"}, {31'd0, low >= INH_CYC}, 32'd1);
        check({name, "_inhibit_dat_final"}, dhi, 32'd1);
        dev_frame(glitch, poke, f);
        check({name, "_frame_model"}, {22'd0, f}, {22'd0, model_frame(d)});
        check({name, "_frame_literal"}, {22'd0, f}, {22'd0, lit});
        d0 = done_cnt;
        e0 = err_cnt;
        dev_ack(ack);
        wait_ready({name, "_ready_after"});
        check({name, "_done_count"}, done_cnt - d0, ack ? 32'd1 : 32'd0);
        check({name, "_err_count"}, err_cnt - e0, ack ? 32'd0 : 32'd1);
    endtask

    initial begin
        int low, dhi, n, d0, e0;
        logic [9:0] f;
        logic s;
        bit busy;

        // Reset state, with a request held during reset that must not act.
        tx_valid = 1'b1;
        repeat (3) @(negedge clk_sys);
        check("rst_ready", {31'd0, tx_ready}, 32'd1);
        check("rst_clk_oe", {31'd0, ps2_clk_oe}, 32'd0);
        check("rst_dat_oe", {31'd0, ps2_dat_oe}, 32'd0);
        check("rst_pulses", {30'd0, tx_done, tx_err}, 32'd0);
        tx_valid = 1'b0;
        reset_n  = 1'b1;
        repeat (5) @(negedge clk_sys);

        // LED command with a request poked mid-frame that must be dropped.
        send(8'hED, 1'b1, 1'b0, 1'b1, 10'h3ED, "ed");
        busy = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk_sys);
            if (ps2_clk_oe) busy = 1'b1;
        end
        check("ignored_req_not_queued", {31'd0, busy}, 32'd0);

        // Parity 0 then parity 1.
        send(8'h01, 1'b1, 1'b0, 1'b0, 10'h201, "x01");
        send(8'hFF, 1'b1, 1'b0, 1'b0, 10'h3FF, "xff");

        // Silent device: watchdog expiry exactly WD_CYC cycles after START entry.
        request(8'h3C);
        wait_start(low, dhi);
        d0 = done_cnt;
        n  = 0;
        while (!tx_err && n < 3 * WD_CYC) begin
            @(negedge clk_sys);
            n++;
        end
        check("wd_err_latency", n, WD_CYC);
        check("wd_clk_released", {31'd0, ps2_clk_oe}, 32'd0);
        check("wd_dat_released", {31'd0, ps2_dat_oe}, 32'd0);
        wait_ready("wd_ready_after");
        check("wd_no_done", done_cnt - d0, 32'd0);

        // Device leaves data high in the ack slot.
        send(8'hA5, 1'b0, 1'b0, 1'b0, 10'h3A5, "nack");

        // Reset after the fourth data bit while the host drives data low for bit 4.
        request(8'hED);
        wait_start(low, dhi);
        repeat (30) @(negedge clk_sys);
        for (int k = 0; k < 4; k++) dev_pulse(1'b0, s);
        dev_clk_low = 1'b1;
        repeat (H) @(negedge clk_sys);
        check("pre_reset_dat_driven", {31'd0, ps2_dat_oe}, 32'd1);
        d0 = done_cnt;
        e0 = err_cnt;
        reset_n = 1'b0;
        #1;
        check("async_rst_clk_oe", {31'd0, ps2_clk_oe}, 32'd0);
        check("async_rst_dat_oe", {31'd0, ps2_dat_oe}, 32'd0);
        @(negedge clk_sys);
        dev_clk_low = 1'b0;
        repeat (4) @(negedge clk_sys);
        reset_n = 1'b1;
        repeat (20) @(negedge clk_sys);
        check("rst_no_pulses", (done_cnt - d0) + (err_cnt - e0), 32'd0);
        send(8'hF4, 1'b1, 1'b0, 1'b0, 10'h2F4, "f4");

        // Short clock glitches during the frame must not shift extra bits.
        send(8'hED, 1'b1, 1'b1, 1'b0, 10'h3ED, "glitch");

        repeat (10) @(negedge clk_sys);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/ps2_host_tx.md
PS2_HOST_TX -- requirements
Module: ps2_host_tx

Interface
REQ-001 SHALL have parameter CLK_HZ, default 48000000, system clock frequency in Hz.
REQ-002 SHALL have parameter INHIBIT_US, default 100, clock-inhibit time before the start bit, in µs.
REQ-003 SHALL have parameter TIMEOUT_MS, default 15, watchdog limit between device clock edges, in ms.
REQ-004 SHALL have parameter FILT, default 8, number of consecutive equal samples needed to accept a ps2 line level.
REQ-005 SHALL have port clk_sys, input, 1: the single clock; all logic on posedge; reset is asynchronous and active-low.
REQ-006 SHALL have port reset_n, input, 1: asynchronous, active-low reset.
REQ-007 SHALL have port tx_data, input, 8: byte to send to the keyboard (for example 0xED LED command).
REQ-008 SHALL have port tx_valid, input, 1: request; accepted only when tx_ready=1.
REQ-009 SHALL have port tx_ready, output, 1: high only in IDLE.
REQ-010 SHALL have port tx_done, output, 1: one-cycle pulse after the device ack bit is sampled low.
REQ-011 SHALL have port tx_err, output, 1: one-cycle pulse on a missing ack or a watchdog timeout.
REQ-012 SHALL have ports ps2_clk_in and ps2_dat_in, inputs, 1 each: raw pad levels.
REQ-013 SHALL have ports ps2_clk_oe and ps2_dat_oe, outputs, 1 each: 1 = drive the pad low; 0 = release (open drain).

Function
REQ-014 SHALL pass each ps2 input through a 2-flop synchronizer, then a FILT-sample filter; the filtered level changes only after FILT equal consecutive samples.
REQ-015 SHALL define a device falling edge as filtered clk going 1->0; it is detected in the cycle the filtered value changes.
REQ-016 SHALL implement states IDLE, INHIBIT, START, BITS, ACK, RECOVER.
REQ-017 IDLE: tx_valid=1 latches tx_data, computes odd parity (parity = ~^tx_data), asserts ps2_clk_oe=1, and moves to INHIBIT on the next cycle.
REQ-018 INHIBIT: ps2_clk_oe=1 for CLK_HZ/1e6*INHIBIT_US cycles (4800 at defaults); ps2_dat_oe rises to 1 for the final cycle; then go to START.
REQ-019 START: ps2_clk_oe=0, ps2_dat_oe=1 (start bit 0), watchdog is loaded; the first falling edge moves to BITS.
REQ-020 BITS: frame = data[0..7] LSB first, then parity, then stop (1). Each falling edge presents the next bit: ps2_dat_oe = ~bit. The 10th edge in this sequence presents stop (ps2_dat_oe=0) and moves to ACK.
REQ-021 ACK: on the next falling edge, sample filtered data; 0 -> tx_done pulse, 1 -> tx_err pulse; either way go to RECOVER.
REQ-022 RECOVER: wait until both filtered lines are 1, then go to IDLE; tx_ready rises in the IDLE cycle.
REQ-023 Watchdog: counter of CLK_HZ/1000*TIMEOUT_MS cycles (720000 at defaults, 20-bit); reloaded on every falling edge in START, BITS and ACK; on expiry, release both lines, pulse tx_err, go to RECOVER.
REQ-024 tx_valid while tx_ready=0 SHALL be ignored, not queued.
REQ-025 tx_done and tx_err SHALL never be asserted in the same cycle.
REQ-026 A falling edge coincident with watchdog expiry SHALL be treated as an edge; the watchdog is reloaded and no error is raised.
REQ-027 Outside INHIBIT/START/BITS, ps2_clk_oe=0; outside INHIBIT-final/START/BITS, ps2_dat_oe=0.

Reset
REQ-028 While reset_n=0: state=IDLE; ps2_clk_oe=0, ps2_dat_oe=0, tx_done=0, tx_err=0, tx_ready=1; counters, shift register and filters cleared with filtered levels set to 1.
REQ-029 Reset asserted mid-frame SHALL release both lines immediately (asynchronously) with no done/err pulse.

Structure
REQ-030 Package ps2_pkg SHALL hold the state enum and the derived cycle-count constants (inhibit and timeout), computed from the parameters.
REQ-031 Sub-module ps2_line_filter (synchronizer + FILT filter, instanced twice) SHALL be used; all other logic stays in ps2_host_tx.

Verification
REQ-032 Send tx_data=0xED with a device model ack=0 -> clk held low ≥4800 cycles; bits 1,0,1,1,0,1,1,1, parity 1, stop 1; one tx_done pulse; tx_ready returns to 1.
REQ-033 Send 0x01 -> parity bit 0 observed; then 0xFF -> parity 1.
REQ-034 Device never clocks after the inhibit -> lines released and tx_err pulses exactly 720000 cycles after START entry.
REQ-035 Device leaves data high in the ack slot -> tx_err pulse, no tx_done.
REQ-036 reset_n pulled low after the 4th data bit -> ps2_clk_oe=ps2_dat_oe=0 within the same cycle; after release, a 0xF4 send completes normally.
REQ-037 Inject 3-cycle glitches on ps2_clk_in during BITS -> no extra bits shifted; frame identical to the glitch-free case.
